// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweep stage.
// Also provides a helper for the table width.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    localparam int TT_N_IN_DEFAULT   = 3;
    localparam int TT_N_FN_DEFAULT   = 2;
    localparam int TT_SETTLE_DEFAULT = 1;

    // One 2^n_in-bit truth table per captured function.
    function automatic int tt_width(input int n_in, input int n_fn);
        return n_fn * (1 << n_in);
    endfunction

endpackage

// File: rtl/truth_table_sweeper.sv
// Steps the evaluator inputs through every minterm, samples each function
// after a programmable settle time and hands the assembled tables downstream.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = TT_N_IN_DEFAULT,
    parameter int N_FN   = TT_N_FN_DEFAULT,
    parameter int SETTLE = TT_SETTLE_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic [N_IN-1:0]                  vars,
    input  logic [N_FN-1:0]                  fn_in,
    output logic                             tt_valid,
    input  logic                             tt_ready,
    output logic [tt_width(N_IN, N_FN)-1:0]  tt_data
);

    localparam int N_MIN = 1 << N_IN;
    localparam int TT_W  = tt_width(N_IN, N_FN);
    // One spare index bit so the last-minterm compare never sees a wrap.
    localparam int IDX_W = N_IN + 1;
    localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_MIN - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);

    tt_state_t          state_reg;
    logic [IDX_W-1:0]   index_reg;
    logic [CNT_W-1:0]   settle_reg;
    logic [N_IN-1:0]    vars_reg;
    logic               busy_reg;
    logic               tt_valid_reg;
    logic [TT_W-1:0]    tt_data_reg;

    logic [IDX_W-1:0]   index_next;
    logic [N_MIN-1:0]   minterm_onehot;
    logic [TT_W-1:0]    tt_data_next;

    assign index_next     = index_reg + IDX_W'(1);
    assign minterm_onehot = N_MIN'(1) << index_reg[N_IN-1:0];

    // Each function's table gets only the current minterm bit replaced;
    // fn_in is copied unfiltered so an X from the evaluator stays visible.
    genvar gi;
    generate
        for (gi = 0; gi < N_FN; gi++) begin : g_capture
            assign tt_data_next[gi*N_MIN +: N_MIN] =
                (tt_data_reg[gi*N_MIN +: N_MIN] & ~minterm_onehot) |
                ({N_MIN{fn_in[gi]}} & minterm_onehot);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            settle_reg   <= '0;
            vars_reg     <= '0;
            busy_reg     <= 1'b0;
            tt_valid_reg <= 1'b0;
            tt_data_reg  <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (start) begin
                        tt_data_reg <= '0;
                        index_reg   <= '0;
                        vars_reg    <= '0;
                        settle_reg  <= SETTLE_LOAD;
                        busy_reg    <= 1'b1;
                        state_reg   <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_reg <= settle_reg - CNT_W'(1);
                    if (settle_reg == CNT_W'(1)) begin
                        state_reg <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    tt_data_reg <= tt_data_next;
                    if (index_reg == LAST_IDX) begin
                        tt_valid_reg <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        index_reg  <= index_next;
                        vars_reg   <= index_next[N_IN-1:0];
                        settle_reg <= SETTLE_LOAD;
                        state_reg  <= DRIVE;
                    end
                end
                DONE: begin
                    // A start arriving with the handshake is dropped, not queued.
                    if (tt_ready) begin
                        tt_valid_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign vars     = vars_reg;
    assign tt_valid = tt_valid_reg;
    assign tt_data  = tt_data_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: evaluators a = ~z, b = 0 at 0,1,2,5,
// driven combinationally or through a two-register delay line.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic        start = 1'b0;
    logic        tt_ready = 1'b0;
    logic        use_delay = 1'b0;
    logic        busy;
    logic        tt_valid;
    logic [2:0]  vars;
    logic [1:0]  fn_in;
    logic [15:0] tt_data;

    logic        start3 = 1'b0;
    logic        tt_ready3 = 1'b0;
    logic        busy3;
    logic        tt_valid3;
    logic [2:0]  vars3;
    logic [1:0]  fn_in3;
    logic [15:0] tt_data3;

    logic [1:0]  dly1_a, dly1_b, dly3_a, dly3_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Evaluator pair: bit 0 = a, bit 1 = b.
    function automatic logic [1:0] eval_fn(input logic [2:0] v);
        logic a, b;
        a = ~v[0];
        b = !(v == 3'd0 || v == 3'd1 || v == 3'd2 || v == 3'd5);
        return {b, a};
    endfunction

    always @(posedge clk) begin
        dly1_a <= eval_fn(vars);
        dly1_b <= dly1_a;
        dly3_a <= eval_fn(vars3);
        dly3_b <= dly3_a;
    end

    assign fn_in  = use_delay ? dly1_b : eval_fn(vars);
    assign fn_in3 = dly3_b;

    truth_table_sweeper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .vars     (vars),
        .fn_in    (fn_in),
        .tt_valid (tt_valid),
        .tt_ready (tt_ready),
        .tt_data  (tt_data)
    );

    truth_table_sweeper #(.SETTLE(3)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start3),
        .busy     (busy3),
        .vars     (vars3),
        .fn_in    (fn_in3),
        .tt_valid (tt_valid3),
        .tt_ready (tt_ready3),
        .tt_data  (tt_data3)
    );

    // Starts a SETTLE=1 sweep and waits for tt_valid; optionally re-pulses start.
    task automatic run_sweep(input int repulse_at, output int cycles,
                             output int vars_bad, output int busy_bad);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        vars_bad = 0;
        busy_bad = 0;
        while (!tt_valid && cycles < 100) begin
            if (vars !== 3'(cycles / 2)) vars_bad++;
            if (busy !== 1'b1) busy_bad++;
            start = (cycles == repulse_at);
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        $display("sweep: cycles=%0d tt_data=%h vars_bad=%0d busy_bad=%0d",
                 cycles, tt_data, vars_bad, busy_bad);
    endtask

    task automatic handshake;
        @(negedge clk);
        tt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tt_ready = 1'b0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (tt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tt_valid); end
        n_cmp++; if (tt_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", tt_data); end
        n_cmp++; if (vars !== 3'd0) begin n_err++; $display("FAIL reset_vars: got %0d want 0", vars); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset: busy=%b tt_valid=%b tt_data=%h vars=%0d", busy, tt_valid, tt_data, vars);
    endtask

    task automatic test_basic_and_hold;
        int cycles, vars_bad, busy_bad, hold_bad;
        run_sweep(-1, cycles, vars_bad, busy_bad);
        n_cmp++; if (cycles !== 16) begin n_err++; $display("FAIL basic_latency: got %0d want 16", cycles); end
        n_cmp++; if (tt_data !== 16'hD855) begin n_err++; $display("FAIL basic_data: got %h want d855", tt_data); end
        n_cmp++; if (vars_bad !== 0) begin n_err++; $display("FAIL basic_vars_order: got %0d bad want 0", vars_bad); end
        n_cmp++; if (busy_bad !== 0) begin n_err++; $display("FAIL basic_busy: got %0d bad want 0", busy_bad); end
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tt_valid !== 1'b1 || tt_data !== 16'hD855 || vars !== 3'd7 || busy !== 1'b1)
                hold_bad++;
        end
        n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL done_hold: got %0d unstable cycles want 0", hold_bad); end
        handshake();
        n_cmp++; if (tt_valid !== 1'b0) begin n_err++; $display("FAIL hs_valid: got %b want 0", tt_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (tt_data !== 16'hD855) begin n_err++; $display("FAIL hs_data_kept: got %h want d855", tt_data); end
        $display("hold+handshake: hold_bad=%0d tt_valid=%b tt_data=%h", hold_bad, tt_valid, tt_data);
    endtask

    task automatic test_start_ignored;
        int cycles, vars_bad, busy_bad, idle_bad;
        run_sweep(5, cycles, vars_bad, busy_bad);
        n_cmp++; if (cycles !== 16) begin n_err++; $display("FAIL repulse_latency: got %0d want 16", cycles); end
        n_cmp++; if (tt_data !== 16'hD855) begin n_err++; $display("FAIL repulse_data: got %h want d855", tt_data); end
        n_cmp++; if (busy_bad !== 0 || vars_bad !== 0) begin n_err++; $display("FAIL repulse_busy_vars: got %0d/%0d bad want 0/0", busy_bad, vars_bad); end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (tt_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL done_start: got valid=%b busy=%b want 1/1", tt_valid, busy); end
        handshake();
        idle_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || tt_valid !== 1'b0) idle_bad++;
            @(negedge clk);
        end
        n_cmp++; if (idle_bad !== 0) begin n_err++; $display("FAIL start_not_queued: got %0d busy cycles want 0", idle_bad); end
        $display("start ignored: cycles=%0d tt_data=%h idle_bad=%0d", cycles, tt_data, idle_bad);
    endtask

    task automatic test_reset_mid;
        int cycles, vars_bad, busy_bad;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || tt_valid !== 1'b0) begin n_err++; $display("FAIL midreset_ctrl: got busy=%b valid=%b want 0/0", busy, tt_valid); end
        n_cmp++; if (tt_data !== 16'h0000) begin n_err++; $display("FAIL midreset_data: got %h want 0000", tt_data); end
        n_cmp++; if (vars !== 3'd0) begin n_err++; $display("FAIL midreset_vars: got %0d want 0", vars); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_sweep(-1, cycles, vars_bad, busy_bad);
        n_cmp++; if (cycles !== 16 || tt_data !== 16'hD855) begin n_err++; $display("FAIL after_reset_sweep: got %0d cycles %h want 16 d855", cycles, tt_data); end
        handshake();
        $display("mid-sweep reset: resweep cycles=%0d tt_data=%h", cycles, tt_data);
    endtask

    task automatic test_settle;
        int cycles, vars_bad, busy_bad;
        apply_reset();
        // Delayed evaluator with SETTLE=1 captures the previous minterm's value.
        use_delay = 1'b1;
        run_sweep(-1, cycles, vars_bad, busy_bad);
        n_cmp++; if (tt_data !== 16'hB0AB) begin n_err++; $display("FAIL delay_settle1: got %h want b0ab", tt_data); end
        handshake();
        use_delay = 1'b0;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start3 = 1'b0;
        cycles = 0;
        while (!tt_valid3 && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        n_cmp++; if (cycles !== 32) begin n_err++; $display("FAIL settle3_latency: got %0d want 32", cycles); end
        n_cmp++; if (tt_data3 !== 16'hD855) begin n_err++; $display("FAIL settle3_data: got %h want d855", tt_data3); end
        n_cmp++; if (vars3 !== 3'd7 || busy3 !== 1'b1) begin n_err++; $display("FAIL settle3_done: got vars=%0d busy=%b want 7/1", vars3, busy3); end
        tt_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tt_ready3 = 1'b0;
        n_cmp++; if (tt_valid3 !== 1'b0 || busy3 !== 1'b0) begin n_err++; $display("FAIL settle3_hs: got valid=%b busy=%b want 0/0", tt_valid3, busy3); end
        $display("settle: settle1_delayed=%h settle3 cycles=%0d tt_data=%h", tt_data, cycles, tt_data3);
    endtask

    task automatic test_start_with_ready;
        int cycles, vars_bad, busy_bad, idle_bad;
        run_sweep(-1, cycles, vars_bad, busy_bad);
        start = 1'b1;
        tt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tt_ready = 1'b0;
        n_cmp++; if (busy !== 1'b0 || tt_valid !== 1'b0) begin n_err++; $display("FAIL start_ready_idle: got busy=%b valid=%b want 0/0", busy, tt_valid); end
        idle_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || vars !== 3'd7) idle_bad++;
        end
        n_cmp++; if (idle_bad !== 0) begin n_err++; $display("FAIL start_ready_no_sweep: got %0d bad cycles want 0", idle_bad); end
        n_cmp++; if (tt_data !== 16'hD855) begin n_err++; $display("FAIL start_ready_data: got %h want d855", tt_data); end
        $display("start+ready in DONE: busy=%b tt_data=%h idle_bad=%0d", busy, tt_data, idle_bad);
    endtask

    initial begin
        test_reset();
        test_basic_and_hold();
        test_start_ignored();
        test_reset_mid();
        test_settle();
        test_start_with_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
